// File: rtl/gf2_poly_divider_pkg.sv
// Shared types and width helpers for the bit-serial GF(2) polynomial divider.
package gf2_div_pkg;

    localparam int unsigned DEF_N = 768;
    localparam int unsigned DEF_M = 384;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned deg_w(input int unsigned m);
        return $clog2(m);
    endfunction

    localparam int unsigned CNT_W = cnt_w(DEF_N);
    localparam int unsigned DEG_W = deg_w(DEF_M);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_DIV,
        ST_DONE
    } div_state_e;

endpackage

// File: rtl/gf2_poly_divider_msb_index.sv
// Priority encoder: index of the highest set bit of vec, plus an all-zero flag.
module gf2_msb_index
    import gf2_div_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             zero
);

    always_comb begin
        idx  = '0;
        zero = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            if (vec[i]) begin
                idx  = IDX_W'(i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2) divider: q = a / b, r = a mod b, one dividend bit per cycle.
// Optional GF2DIV_SKIP_EN: skip leading zero dividend bits for latency deg(a)+3.
module gf2_poly_divider
    import gf2_div_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned M = DEF_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [M-1:0] b,
    output logic         busy,
    output logic         valid,
    output logic         err,
    output logic [N-1:0] q,
    output logic [M-1:0] r
);

    localparam int unsigned CW = cnt_w(N);
    localparam int unsigned DW = deg_w(M);

    div_state_e    state_q, state_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  qsh_q, qsh_d;
    logic [N-1:0]  q_q, q_d;
    logic [M-1:0]  dvs_q, dvs_d;
    logic [M-1:0]  rem_q, rem_d;
    logic [M-1:0]  r_q, r_d;
    logic [DW-1:0] db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [DW-1:0] b_deg;
    logic          b_zero;
    logic [M-1:0]  t_raw;
    logic [M-1:0]  t_red;
    logic          qbit;
    logic [N-1:0]  qsh_next;

    gf2_msb_index #(.W(M), .IDX_W(DW)) u_b_msb (
        .vec  (dvs_q),
        .idx  (b_deg),
        .zero (b_zero)
    );

`ifdef GF2DIV_SKIP_EN
    localparam int unsigned AW = deg_w(N);

    logic [AW-1:0] a_deg;
    logic          a_zero;
    logic [CW-1:0] run_len;
    logic [CW-1:0] shamt;

    gf2_msb_index #(.W(N), .IDX_W(AW)) u_a_msb (
        .vec  (dvd_q),
        .idx  (a_deg),
        .zero (a_zero)
    );

    assign run_len = a_zero ? CW'(1) : CW'(a_deg) + CW'(1);
    assign shamt   = CW'(N - 1) - CW'(a_deg);
`endif

    // rem always has degree below db, so its top bit is free to shift out.
    assign t_raw    = {rem_q[M-2:0], dvd_q[N-1]};
    assign qbit     = t_raw[db_q];
    assign t_red    = qbit ? (t_raw ^ dvs_q) : t_raw;
    assign qsh_next = {qsh_q[N-2:0], qbit};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        qsh_d   = qsh_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d   = a;
                    dvs_d   = b;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                db_d = b_deg;
                if (b_zero) begin
                    err_d   = 1'b1;
                    q_d     = '0;
                    r_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    rem_d   = '0;
                    qsh_d   = '0;
`ifdef GF2DIV_SKIP_EN
                    dvd_d   = dvd_q << shamt;
                    cnt_d   = run_len;
`else
                    cnt_d   = CW'(N);
`endif
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                dvd_d = dvd_q << 1;
                rem_d = t_red;
                qsh_d = qsh_next;
                cnt_d = cnt_q - CW'(1);
                // Results are captured on the last step so they line up with valid.
                if (cnt_q == CW'(1)) begin
                    err_d   = 1'b0;
                    q_d     = qsh_next;
                    r_d     = t_red;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qsh_q   <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            qsh_q   <= qsh_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    assign busy  = (state_q == ST_NORM) || (state_q == ST_DIV);
    assign valid = (state_q == ST_DONE);
    assign err   = err_q;
    assign q     = q_q;
    assign r     = r_q;

endmodule
